// File: rtl/dds_phase_gen.sv
// dds_phase_gen: frequency-to-tuning-word divider feeding a phase accumulator that addresses a waveform ROM
module dds_phase_gen #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 8,
  parameter int SEL_W  = 2,
  parameter int FREQ_W = 20,
  parameter int CLK_HZ = 50_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic                    cfg_clr,
  input  logic [FREQ_W-1:0]       freq_in,
  input  logic [SEL_W-1:0]        wave_sel,
  input  logic [ADDR_W-1:0]       phase_in,
  output logic [SEL_W+ADDR_W-1:0] rom_addr,
  output logic [ACC_W-1:0]        fword,
  output logic                    wrap,
  output logic                    cfg_err
);
  localparam int N  = FREQ_W + ACC_W;
  localparam int RW = $clog2(CLK_HZ) + 1;
  localparam int CW = $clog2(N);
  localparam logic [RW-1:0] DEN  = RW'(CLK_HZ);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  typedef enum logic [1:0] {IDLE, DIV, LOAD} state_t;
  state_t state, state_nx;
  logic [ACC_W-1:0] acc;
  logic [SEL_W-1:0] sel_r, sel_s;
  logic [ADDR_W-1:0] phase_r, phase_s, top;
  logic clr_s;
  logic [N-1:0] num;
  logic [RW-1:0] rem;
  logic [CW-1:0] cnt;
  logic [RW:0] trial;
  logic ge, sat, do_clr;
  logic [ACC_W:0] sum;
  // num starts as the dividend and fills with quotient bits from the bottom
  assign trial = {rem, num[N-1]};
  assign ge = trial >= {1'b0, DEN};
  assign sat = |num[N-1:ACC_W];
  assign sum = {1'b0, acc} + {1'b0, fword};
  assign do_clr = (state == LOAD) && clr_s;
  assign top = acc[ACC_W-1 -: ADDR_W] + phase_r;
  assign rom_addr = {sel_r, top};
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  always_comb begin
    cfg_ready = state == IDLE;
    state_nx = (state == IDLE) ? (cfg_valid ? DIV : IDLE) :
               (state == DIV)  ? ((cnt == LAST) ? LOAD : DIV) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      fword <= '0;
      sel_r <= '0;
      phase_r <= '0;
      sel_s <= '0;
      phase_s <= '0;
      clr_s <= 1'b0;
      num <= '0;
      rem <= '0;
      cnt <= '0;
      wrap <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      acc <= do_clr ? '0 : sum[ACC_W-1:0];
      wrap <= !do_clr && sum[ACC_W];
      cfg_err <= (state == LOAD) && sat;
      if (state == IDLE && cfg_valid) begin
        num <= {freq_in, {ACC_W{1'b0}}};
        rem <= '0;
        cnt <= '0;
        sel_s <= wave_sel;
        phase_s <= phase_in;
        clr_s <= cfg_clr;
      end
      if (state == DIV) begin
        rem <= ge ? RW'(trial - {1'b0, DEN}) : RW'(trial);
        num <= {num[N-2:0], ge};
        cnt <= cnt + CW'(1);
      end
      if (state == LOAD) begin
        fword <= sat ? '1 : num[ACC_W-1:0];
        sel_r <= sel_s;
        phase_r <= phase_s;
      end
    end
  end
endmodule

// File: tb/tb_dds_phase_gen.sv
// tb_dds_phase_gen: randomized and directed checks of dds_phase_gen against an arithmetic reference model
module tb_dds_phase_gen;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  logic cfg_valid = 0, cfg_clr = 0;
  logic [19:0] freq_in = 0;
  logic [1:0] wave_sel = 0;
  logic [7:0] phase_in = 0;
  logic cfg_ready, wrap, cfg_err;
  logic [9:0] rom_addr;
  logic [31:0] fword;
  logic cfg_valid_b = 0;
  logic [19:0] freq_in_b = 0;
  logic cfg_ready_b, wrap_b, cfg_err_b;
  logic [9:0] rom_addr_b;
  logic [31:0] fword_b;
  int total = 0, bad = 0;

  dds_phase_gen u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_clr(cfg_clr),
    .freq_in(freq_in), .wave_sel(wave_sel), .phase_in(phase_in), .rom_addr(rom_addr),
    .fword(fword), .wrap(wrap), .cfg_err(cfg_err)
  );

  dds_phase_gen #(.CLK_HZ(1000)) u_sat (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b), .cfg_clr(1'b0),
    .freq_in(freq_in_b), .wave_sel(2'd0), .phase_in(8'd0), .rom_addr(rom_addr_b),
    .fword(fword_b), .wrap(wrap_b), .cfg_err(cfg_err_b)
  );

  function automatic logic [31:0] fw_of(input longint unsigned f, input longint unsigned hz);
    longint unsigned q;
    q = (f << 32) / hz;
    return (q > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
  endfunction

  task automatic start_req(input logic [19:0] f, input logic [1:0] s, input logic [7:0] p, input logic c);
    cfg_valid = 1; freq_in = f; wave_sel = s; phase_in = p; cfg_clr = c;
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 0;
    freq_in = 20'($urandom);
    wave_sel = 2'($urandom);
    phase_in = 8'($urandom);
    cfg_clr = 1'($urandom);
  endtask

  task automatic wait_commit(input bit poke, output int lows);
    lows = 0;
    while (cfg_ready !== 1'b1 && lows < 200) begin
      if (poke && lows == 10) begin
        cfg_valid = 1;
        freq_in = 20'($urandom);
      end else cfg_valid = 0;
      lows++;
      @(negedge clk);
    end
    cfg_valid = 0;
  endtask

  task automatic test_accumulate(input logic [31:0] fw, input logic [1:0] s, input logic [7:0] p,
                                 input logic [31:0] a0, input int n, output int first_wrap);
    longint unsigned t, tp;
    logic [7:0] b;
    logic [9:0] want;
    logic wwant;
    first_wrap = 0;
    b = a0[31:24] + p;
    want = {s, b};
    total++;
    if (rom_addr !== want) begin
      bad++;
      $display("FAIL commit_addr rom_addr=%h want %h", rom_addr, want);
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      t = 64'(a0) + 64'(k) * 64'(fw);
      tp = t - 64'(fw);
      wwant = (t >> 32) != (tp >> 32);
      b = t[31:24] + p;
      want = {s, b};
      total++;
      if (rom_addr !== want || wrap !== wwant) begin
        bad++;
        $display("FAIL accum k=%0d rom_addr=%h wrap=%b want %h %b", k, rom_addr, wrap, want, wwant);
      end
      if (wwant && first_wrap == 0) first_wrap = k;
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      total++;
      if (rom_addr !== 0 || fword !== 0 || wrap !== 0 || cfg_ready !== 1 || cfg_err !== 0 ||
          fword_b !== 0 || cfg_ready_b !== 1) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d rom_addr=%h fword=%h wrap=%b ready=%b err=%b want 0 0 0 1 0",
                 i, rom_addr, fword, wrap, cfg_ready, cfg_err);
      end
    end
  endtask

  task automatic test_basic();
    int lows, fwr;
    start_req(20'd1000, 2'd1, 8'd0, 1'b0);
    wait_commit(0, lows);
    total++;
    if (lows !== 53) begin bad++; $display("FAIL basic_busy lows=%0d want 53", lows); end
    total++;
    if (fword !== 32'd85899 || cfg_err !== 0) begin
      bad++;
      $display("FAIL basic_fword fword=%0d err=%b want 85899 0", fword, cfg_err);
    end
    test_accumulate(32'd85899, 2'd1, 8'd0, 32'd0, 60, fwr);
  endtask

  task automatic test_fast();
    int lows, fwr;
    start_req(20'd1_000_000, 2'd3, 8'd17, 1'b1);
    wait_commit(0, lows);
    total++;
    if (lows !== 53 || fword !== 32'd85899345) begin
      bad++;
      $display("FAIL fast_commit lows=%0d fword=%0d want 53 85899345", lows, fword);
    end
    test_accumulate(32'd85899345, 2'd3, 8'd17, 32'd0, 60, fwr);
    total++;
    if (fwr !== 51) begin bad++; $display("FAIL fast_first_wrap got=%0d want 51", fwr); end
  endtask

  task automatic test_offset();
    int lows, fwr;
    logic [31:0] fw1, a0;
    start_req(20'd0, 2'd2, 8'd64, 1'b1);
    wait_commit(0, lows);
    total++;
    if (fword !== 0 || rom_addr !== 10'h240) begin
      bad++;
      $display("FAIL offset64 fword=%h rom_addr=%h want 0 240", fword, rom_addr);
    end
    test_accumulate(32'd0, 2'd2, 8'd64, 32'd0, 20, fwr);
    fw1 = fw_of(64'd464772, 64'd50_000_000);
    start_req(20'd464772, 2'd2, 8'd64, 1'b1);
    wait_commit(0, lows);
    total++;
    if (fword !== fw1) begin bad++; $display("FAIL offset_fw fword=%h want %h", fword, fw1); end
    start_req(20'd0, 2'd2, 8'd200, 1'b0);
    wait_commit(0, lows);
    a0 = 32'(64'd54 * 64'(fw1));
    total++;
    if (rom_addr !== 10'h248) begin bad++; $display("FAIL offset200 rom_addr=%h want 248", rom_addr); end
    test_accumulate(32'd0, 2'd2, 8'd200, a0, 10, fwr);
  endtask

  task automatic test_busy_ignore();
    int lows, fwr;
    logic [19:0] f;
    f = 20'($urandom_range(1, 1048575));
    start_req(f, 2'd1, 8'd5, 1'b1);
    wait_commit(1, lows);
    total++;
    if (lows !== 53 || fword !== fw_of(64'(f), 64'd50_000_000)) begin
      bad++;
      $display("FAIL busy_ignore lows=%0d fword=%h want 53 %h", lows, fword, fw_of(64'(f), 64'd50_000_000));
    end
    test_accumulate(fword, 2'd1, 8'd5, 32'd0, 10, fwr);
  endtask

  task automatic test_random();
    int lows, fwr;
    logic [19:0] f;
    logic [1:0] s;
    logic [7:0] p;
    logic [31:0] fw;
    for (int i = 0; i < 4; i++) begin
      f = 20'($urandom_range(1, 1048575));
      s = 2'($urandom);
      p = 8'($urandom);
      fw = fw_of(64'(f), 64'd50_000_000);
      start_req(f, s, p, 1'b1);
      wait_commit(0, lows);
      total++;
      if (lows !== 53 || fword !== fw || cfg_err !== 0) begin
        bad++;
        $display("FAIL random f=%0d lows=%0d fword=%h err=%b want 53 %h 0", f, lows, fword, cfg_err, fw);
      end
      test_accumulate(fw, s, p, 32'd0, 40, fwr);
    end
  endtask

  task automatic test_saturation();
    int n;
    logic [19:0] fr [2] = '{20'd1000, 20'd999};
    logic [31:0] fw;
    logic ew;
    for (int i = 0; i < 2; i++) begin
      fw = fw_of(64'(fr[i]), 64'd1000);
      ew = fr[i] >= 20'd1000;
      cfg_valid_b = 1;
      freq_in_b = fr[i];
      @(posedge clk);
      @(negedge clk);
      cfg_valid_b = 0;
      freq_in_b = 20'($urandom);
      n = 0;
      while (cfg_ready_b !== 1'b1 && n < 200) begin n++; @(negedge clk); end
      total++;
      if (n !== 53 || fword_b !== fw || cfg_err_b !== ew) begin
        bad++;
        $display("FAIL sat_commit f=%0d lows=%0d fword=%h err=%b want 53 %h %b", fr[i], n, fword_b, cfg_err_b, fw, ew);
      end
      @(negedge clk);
      total++;
      if (cfg_err_b !== 0) begin bad++; $display("FAIL sat_pulse err=%b want 0", cfg_err_b); end
    end
    total++;
    if (fword_b !== 32'd4290672328) begin bad++; $display("FAIL sat_999 fword=%0d want 4290672328", fword_b); end
  endtask

  task automatic test_abort();
    start_req(20'd123456, 2'd3, 8'd99, 1'b1);
    repeat (19) @(negedge clk);
    total++;
    if (cfg_ready !== 0) begin bad++; $display("FAIL abort_busy ready=%b want 0", cfg_ready); end
    rst_n = 0;
    @(negedge clk);
    total++;
    if (rom_addr !== 0 || fword !== 0 || wrap !== 0 || cfg_ready !== 1 || cfg_err !== 0) begin
      bad++;
      $display("FAIL abort_reset rom_addr=%h fword=%h wrap=%b ready=%b err=%b want 0 0 0 1 0",
               rom_addr, fword, wrap, cfg_ready, cfg_err);
    end
    rst_n = 1;
    repeat (60) @(negedge clk);
    total++;
    if (rom_addr !== 0 || fword !== 0 || cfg_ready !== 1) begin
      bad++;
      $display("FAIL abort_discard rom_addr=%h fword=%h ready=%b want 0 0 1", rom_addr, fword, cfg_ready);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_fast();
    test_offset();
    test_busy_ignore();
    test_random();
    test_saturation();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
